// File: rtl/m_fetch_queue_if.sv
// rtl/m_fetch_queue_if.sv - fetch/decode and instruction-memory signal bundle for m_fetch_queue
//
// Purpose: groups the signals exchanged between the fetch queue and its
// surroundings. The master modport is the fetch queue side; slave is the
// environment (decode stage, branch resolution, instruction memory).
// Signals:
//   w_stall      decode cannot accept the head entry this cycle
//   w_redirect   taken branch/jump resolved downstream, flush the queue
//   w_tpc        redirect target PC, valid with w_redirect
//   w_imem_addr  byte address to instruction memory (the fetch PC)
//   w_imem_data  instruction word returned combinationally for w_imem_addr
//   w_valid      head entry is valid
//   w_pc         PC of the head entry (0 when empty)
//   w_ir         instruction of the head entry (NOP when empty)
//   w_count      current occupancy, $clog2(DEPTH)+1 bits
interface m_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_stall;
  logic          w_redirect;
  logic [31:0]   w_tpc;
  logic [31:0]   w_imem_addr;
  logic [31:0]   w_imem_data;
  logic          w_valid;
  logic [31:0]   w_pc;
  logic [31:0]   w_ir;
  logic [CW-1:0] w_count;

  modport master (
    input  w_stall, w_redirect, w_tpc, w_imem_data,
    output w_imem_addr, w_valid, w_pc, w_ir, w_count
  );

  modport slave (
    output w_stall, w_redirect, w_tpc, w_imem_data,
    input  w_imem_addr, w_valid, w_pc, w_ir, w_count
  );
endinterface

// File: rtl/m_fetch_queue.sv
// rtl/m_fetch_queue.sv - instruction fetch stage with prefetch queue
//
// Purpose: fetches one word per cycle from a combinational instruction
// memory, tags it with its PC and buffers it in a DEPTH-entry FIFO. The head
// entry is presented to decode; decode stalls are absorbed and a redirect
// flushes the queue and restarts fetch at the target.
// Ports:
//   w_clk   rising-edge clock
//   w_rst   synchronous active-high reset
//   bus     m_fetch_queue_if.master (stall/redirect/target in, imem
//           address out, imem data in, head valid/pc/ir and count out)
// Parameters: DEPTH (power of two, >= 2), RESET_PC, NOP.
// Optional build macro: FETCH_JAL_PRED_EN - when defined, an enqueued JAL
// steers the next fetch PC to its target instead of PC+4.
module m_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic            w_clk,
  input  logic            w_rst,
  m_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   ir_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          valid;
  logic          deq;
  logic          enq;
  logic [31:0]   next_pc;

  assign valid = (count != '0);
  assign deq   = valid && !bus.w_stall;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign enq   = !bus.w_redirect && ((count < CW'(DEPTH)) || deq);

`ifdef FETCH_JAL_PRED_EN
  logic [31:0] jal_imm;
  // J-type immediate {imm[20|10:1|11|19:12], 0}, sign-extended to 32 bits.
  assign jal_imm = {{12{bus.w_imem_data[31]}}, bus.w_imem_data[19:12],
                    bus.w_imem_data[20], bus.w_imem_data[30:21], 1'b0};
  assign next_pc = (bus.w_imem_data[6:0] == 7'h6F) ? fetch_pc + jal_imm
                                                   : fetch_pc + 32'd4;
`else
  assign next_pc = fetch_pc + 32'd4;
`endif

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.w_redirect) begin
      // Flush wins over any enqueue/dequeue in the same cycle.
      fetch_pc <= bus.w_tpc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= next_pc;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (deq && !enq) begin
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge w_clk) begin
    if (!w_rst && enq) begin
      pc_mem[wr_ptr] <= fetch_pc;
      ir_mem[wr_ptr] <= bus.w_imem_data;
    end
  end

  assign bus.w_imem_addr = fetch_pc;
  assign bus.w_valid     = valid;
  assign bus.w_pc        = valid ? pc_mem[rd_ptr] : 32'h0;
  assign bus.w_ir        = valid ? ir_mem[rd_ptr] : NOP;
  assign bus.w_count     = count;
endmodule

// File: tb/tb_m_fetch_queue.sv
// tb/tb_m_fetch_queue.sv - self-checking bench for m_fetch_queue
module tb_m_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic w_clk;
  logic w_rst;
  m_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  m_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus.master)
  );

  logic [31:0] mem [64];
  assign bus.w_imem_data = mem[bus.w_imem_addr[7:2]];

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference: queue of {pc, ir} entries plus the fetch PC.
  logic [63:0] mq [$];
  logic [31:0] mpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir);
`ifdef FETCH_JAL_PRED_EN
    if (ir[6:0] == 7'h6F) begin
      int imm;
      imm = int'(ir[31]) * -1048576 + int'(ir[19:12]) * 4096 + int'(ir[20]) * 2048
            + int'(ir[30:21]) * 2;
      return pc + 32'(imm);
    end
`endif
    return pc + 32'd4;
  endfunction

  // Advance the model with the currently driven inputs, clock once, compare.
  task automatic cycle();
    bit do_deq, do_enq;
    if (w_rst) begin
      mq.delete();
      mpc = RESET_PC;
    end else if (bus.w_redirect) begin
      mq.delete();
      mpc = bus.w_tpc;
    end else begin
      do_deq = (mq.size() != 0) && !bus.w_stall;
      do_enq = (mq.size() < DEPTH) || do_deq;
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        mq.push_back({mpc, mem[mpc[7:2]]});
        mpc = model_next(mpc, mem[mpc[7:2]]);
      end
    end
    @(posedge w_clk);
    #1;
    check("valid", 32'(bus.w_valid), 32'(mq.size() != 0));
    check("count", 32'(bus.w_count), 32'(mq.size()));
    check("imem_addr", bus.w_imem_addr, mpc);
    check("pc", bus.w_pc, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
    check("ir", bus.w_ir, (mq.size() != 0) ? mq[0][31:0] : NOP);
  endtask

  task automatic idle_inputs();
    w_rst = 1'b0;
    bus.w_stall = 1'b0;
    bus.w_redirect = 1'b0;
    bus.w_tpc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    w_rst = 1'b1;
    cycle();
    w_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i][6:0] == 7'h6F) mem[i][0] = 1'b0;
    end
    mem[0] = 32'h00700093;
    mem[1] = 32'h00102423;
    mem[2] = 32'h00802183;
    idle_inputs();
    mpc = RESET_PC;
    @(negedge w_clk);

    // Reset state
    do_reset();
    check("rst_count", 32'(bus.w_count), 32'd0);
    check("rst_ir", bus.w_ir, NOP);
    check("rst_addr", bus.w_imem_addr, RESET_PC);
    check("rst_valid", 32'(bus.w_valid), 32'd0);

    // Sequential fetch, no stall
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("seq_pc", bus.w_pc, 32'(k * 4));
      check("seq_ir", bus.w_ir, mem[k]);
      check("seq_count", 32'(bus.w_count), 32'd1);
    end

    // Stall fill from reset
    do_reset();
    bus.w_stall = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    check("fill_count", 32'(bus.w_count), 32'd4);
    check("fill_addr", bus.w_imem_addr, 32'h10);
    check("fill_pc", bus.w_pc, 32'h0);
    bus.w_stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check("drain_pc", bus.w_pc, 32'(k * 4));
    end

    // Full queue with a single-cycle dequeue
    do_reset();
    bus.w_stall = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    bus.w_stall = 1'b0;
    cycle();
    check("fulldeq_count", 32'(bus.w_count), 32'd4);
    check("fulldeq_addr", bus.w_imem_addr, 32'h14);
    check("fulldeq_pc", bus.w_pc, 32'h4);
    bus.w_stall = 1'b1;
    cycle();

    // Redirect at count 3
    do_reset();
    bus.w_stall = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    check("redir_pre_count", 32'(bus.w_count), 32'd3);
    bus.w_redirect = 1'b1;
    bus.w_tpc = 32'h40;
    cycle();
    check("redir_valid", 32'(bus.w_valid), 32'd0);
    check("redir_ir", bus.w_ir, NOP);
    check("redir_addr", bus.w_imem_addr, 32'h40);
    bus.w_redirect = 1'b0;
    bus.w_stall = 1'b0;
    cycle();
    check("redir_pc", bus.w_pc, 32'h40);
    check("redir_valid2", 32'(bus.w_valid), 32'd1);

    // Mid-run reset overriding a redirect
    do_reset();
    bus.w_stall = 1'b1;
    for (int k = 0; k < 2; k++) cycle();
    w_rst = 1'b1;
    bus.w_redirect = 1'b1;
    bus.w_tpc = 32'h80;
    cycle();
    check("midrst_count", 32'(bus.w_count), 32'd0);
    check("midrst_addr", bus.w_imem_addr, RESET_PC);
    idle_inputs();

`ifdef FETCH_JAL_PRED_EN
    mem[1] = 32'h0100006F;
    do_reset();
    cycle();
    check("jal_pc0", bus.w_pc, 32'h0);
    cycle();
    check("jal_pc1", bus.w_pc, 32'h4);
    cycle();
    check("jal_pc2", bus.w_pc, 32'h14);
    mem[1] = 32'h00102423;
`endif

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      w_rst = ($urandom_range(0, 99) == 0);
      bus.w_stall = ($urandom_range(0, 99) < 40);
      bus.w_redirect = ($urandom_range(0, 99) < 5);
      bus.w_tpc = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/m_fetch_queue.md
Name: m_fetch_queue

Overview:
- Instruction fetch stage with prefetch queue.
- Sits directly upstream of the decode/register-read stage of m_proc4.
- Each cycle, reads one word from the combinational instruction memory, tags it with its PC, and buffers it in a small FIFO.
- Presents the head entry to decode, absorbs decode stalls without losing instructions, and flushes on a branch/jump redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h0, fetch PC loaded on reset.
- NOP, 32'h00000013, instruction word presented when the queue is empty (addi x0,x0,0).

Ports:
- w_clk  input  1  clock, rising edge.
- w_rst  input  1  synchronous, active-high reset.
- w_stall  input  1  decode cannot accept the head entry this cycle.
- w_redirect  input  1  taken branch/jump resolved downstream; flush the queue.
- w_tpc  input  32  redirect target PC, valid with w_redirect.
- w_imem_addr  output  32  byte address to instruction memory; equals the fetch PC.
- w_imem_data  input  32  instruction word, combinationally returned for w_imem_addr.
- w_valid  output  1  head entry is valid.
- w_pc  output  32  PC of the head entry.
- w_ir  output  32  instruction of the head entry; NOP when w_valid=0.
- w_count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Interface: one clock, w_clk. Reset w_rst is synchronous and active-high.
- Reset (w_rst=1 at an edge):
  - fetch PC <= RESET_PC.
  - Queue emptied: rd/wr pointers 0, count 0.
  - Outputs after the edge: w_valid=0, w_pc=0, w_ir=NOP, w_count=0, w_imem_addr=RESET_PC.
- Reset asserted mid-operation discards all entries. It overrides redirect, stall, enqueue and dequeue.
- Dequeue condition: deq = w_valid & ~w_stall. Entry removed at the next edge.
- Enqueue condition: enq = ~w_redirect & (count<DEPTH | deq).
  - On enq, {fetch PC, w_imem_data} is written at the write pointer.
  - fetch PC advances by 4 (or the JAL target, see Optional Feature).
  - A full queue with a simultaneous dequeue still enqueues; count stays DEPTH.
  - When not enqueuing, fetch PC holds.
- Count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- Redirect (w_redirect=1, w_rst=0):
  - Queue flushed; count 0 at the next edge. No enqueue or dequeue that cycle.
  - fetch PC <= w_tpc.
  - First instruction from w_tpc is valid after the following edge, i.e. a 2-edge redirect penalty.
- Outputs w_valid, w_pc, w_ir are driven from queue storage at the read pointer (registered state, no combinational path from w_imem_data).
  - w_valid = (count != 0).
  - w_pc, w_ir are forced to 0 / NOP when empty.
- Latency: from reset release, the first instruction is valid after one edge. Steady state, with no stall, is 1 instruction per cycle.
- Stall with a full queue: fetch PC holds and w_imem_addr is stable.
- Arithmetic: PC is 32-bit, wraps modulo 2^32. w_tpc low 2 bits are used as given (no alignment check).

Optional Feature:
- Macro: FETCH_JAL_PRED_EN.
- Defined:
  - When the enqueued w_imem_data has opcode 7'h6F (JAL), the next fetch PC is fetch PC + sign-extended J-immediate {imm[20|10:1|11|19:12],0} instead of +4.
  - The JAL itself is still enqueued normally.
  - A redirect still overrides.
- Undefined: fetch PC always advances by +4 on enqueue; JAL is resolved only via w_redirect.

Test Plan:
- Reset, then sequential fetch:
  - Stimulus: mem[0]=32'h00700093, mem[1]=32'h00102423, mem[2]=32'h00802183, no stall.
  - Response: after edges 1/2/3, w_pc=0/4/8 with matching w_ir; w_valid=1 from edge 1; w_count=1 steady.
- Stall fill:
  - Stimulus: w_stall=1 for 6 cycles from reset.
  - Response: w_count reaches 4 (DEPTH) and holds; w_imem_addr holds 32'h10; w_pc stays 0.
  - After release: heads 0,4,8,C,10 on consecutive cycles, with no gaps.
- Full plus simultaneous dequeue:
  - Stimulus: queue full, w_stall dropped for one cycle.
  - Response: w_count stays 4; fetch PC advances by 4; w_pc advances by 4.
- Redirect:
  - Stimulus: w_redirect=1, w_tpc=32'h40 while count=3.
  - Response: next edge w_valid=0, w_ir=NOP, w_imem_addr=32'h40; the edge after that, w_pc=32'h40, w_valid=1.
- Mid-run reset:
  - Stimulus: w_rst=1 for one cycle while count=2 and w_redirect=1.
  - Response: w_count=0, w_imem_addr=RESET_PC; the redirect is ignored.
- With FETCH_JAL_PRED_EN:
  - Stimulus: mem[1]=32'h0100006F (jal x0,+16).
  - Response: fetched PCs are 0, 4, 14; PC 8 is never fetched.
